// File: rtl/uart_rx_multi.sv
// uart_rx_multi: oversampling UART receiver with 3-tap majority vote,
// 5-8 data bits, optional parity, 1/2 stop bits, break detection and a
// first-word-fall-through character FIFO carrying per-character error flags.
module uart_rx_multi #(
  parameter int OSR     = 16,
  parameter int FIFO_AW = 4,
  parameter int TO_BITS = 40
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               baud_tick_i,
  input  logic               rx_i,
  input  logic [1:0]         data_bits_i,
  input  logic               parity_en_i,
  input  logic               even_parity_i,
  input  logic               stop2_i,
  input  logic               rd_en_i,
  input  logic               ov_clr_i,
  input  logic [FIFO_AW:0]   rx_thr_i,
  output logic [7:0]         rx_data_o,
  output logic               err_parity_o,
  output logic               err_frame_o,
  output logic               err_break_o,
  output logic               rx_overrun_o,
  output logic               rx_full_o,
  output logic               rx_not_empty_o,
  output logic [FIFO_AW:0]   rx_level_o,
  output logic               rx_thr_o,
  output logic               rx_timeout_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(OSR);
  localparam int CW    = $clog2(TO_BITS + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } entry_t;

  // Synchronizer and edge-detect history
  logic rx_meta, rxs, rxs_q;
  // Bit timing and majority vote
  logic [TW-1:0] tick_cnt;
  logic          tick_wrap, samp0, samp1, vote, vote_now, start_det;
  // Frame state
  state_t     state_q, state_d;
  logic [1:0] cfg_bits;
  logic       cfg_par, cfg_even, cfg_stop2;
  logic [7:0] shreg, data_aligned;
  logic [2:0] bit_cnt, last_bit;
  logic       any_one, perr_q, ferr_q, ferr_fin;
  logic       frame_end, brk_frame;
  logic       wr_stb;
  entry_t     wr_entry;
  // FIFO
  entry_t             mem [DEPTH];
  entry_t             head;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               empty, full, do_rd, do_wr;
  // Idle timeout
  logic [CW-1:0] to_cnt;
  logic          to_clr;

  // Two-flop synchronizer plus one history flop for falling-edge detection;
  // all reset high so a reset release never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      // NOTE: clocked state always uses non-blocking assignment so every
      // flop samples the pre-edge value of its neighbours.
      rx_meta <= rx_i;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
    end
  end

  assign start_det = (state_q == IDLE) && rxs_q && !rxs;
  assign tick_wrap = baud_tick_i && (tick_cnt == TW'(OSR - 1));
  assign vote_now  = baud_tick_i && (tick_cnt == TW'(OSR / 2 + 1)) &&
                     (state_q != IDLE) && (state_q != BRK_WAIT);
  assign vote      = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);

  // Oversample tick counter, realigned on each start edge, plus the two
  // early majority-vote samples taken just before mid-bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tick_cnt <= '0;
      samp0    <= 1'b1;
      samp1    <= 1'b1;
    end else begin
      if (start_det)        tick_cnt <= '0;
      else if (tick_wrap)   tick_cnt <= '0;
      else if (baud_tick_i) tick_cnt <= tick_cnt + 1'b1;
      if (baud_tick_i && tick_cnt == TW'(OSR / 2 - 1)) samp0 <= rxs;
      if (baud_tick_i && tick_cnt == TW'(OSR / 2))     samp1 <= rxs;
    end
  end

  assign last_bit     = {1'b0, cfg_bits} + 3'd4;
  assign data_aligned = shreg >> (2'd3 - cfg_bits);
  assign ferr_fin     = ferr_q | ~vote;

  // Frame state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; frame_end flags the final stop vote of a frame
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case below can leave a value held (which would be a latch).
    state_d   = state_q;
    frame_end = 1'b0;
    brk_frame = 1'b0;
    unique case (state_q)
      IDLE:     if (start_det) state_d = START;
      START:    if (vote_now) state_d = vote ? IDLE : DATA;
      DATA:     if (vote_now && bit_cnt == last_bit)
                  state_d = cfg_par ? PARITY : STOP1;
      PARITY:   if (vote_now) state_d = STOP1;
      STOP1, STOP2: begin
        if (vote_now) begin
          if (state_q == STOP1 && cfg_stop2) begin
            state_d = STOP2;
          end else begin
            frame_end = 1'b1;
            brk_frame = !any_one && !vote;
            state_d   = brk_frame ? BRK_WAIT : IDLE;
          end
        end
      end
      BRK_WAIT: if (rxs) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Character datapath: config latch, shift register, error accumulation,
  // and the registered FIFO write one cycle after the final stop vote.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cfg_bits  <= 2'b00;
      cfg_par   <= 1'b0;
      cfg_even  <= 1'b0;
      cfg_stop2 <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      any_one   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      wr_stb    <= 1'b0;
      wr_entry  <= '0;
    end else begin
      if (start_det) begin
        cfg_bits  <= data_bits_i;
        cfg_par   <= parity_en_i;
        cfg_even  <= even_parity_i;
        cfg_stop2 <= stop2_i;
        shreg     <= '0;
        bit_cnt   <= '0;
        any_one   <= 1'b0;
        perr_q    <= 1'b0;
        ferr_q    <= 1'b0;
      end else if (vote_now) begin
        unique case (state_q)
          DATA: begin
            shreg   <= {vote, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            any_one <= any_one | vote;
          end
          PARITY: begin
            perr_q  <= (^shreg) ^ vote ^ ~cfg_even;
            any_one <= any_one | vote;
          end
          STOP1: begin
            ferr_q  <= ferr_q | ~vote;
            any_one <= any_one | vote;
          end
          default: ;
        endcase
      end
      wr_stb <= frame_end;
      if (frame_end) begin
        wr_entry <= brk_frame ? {8'h00, 1'b0, 1'b1, 1'b1}
                              : {data_aligned, perr_q, ferr_fin, 1'b0};
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == (FIFO_AW + 1)'(DEPTH));
  assign do_rd = rd_en_i && !empty;
  assign do_wr = wr_stb && (!full || do_rd);

  // FIFO storage
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: storage is cleared on reset so the head outputs are defined
      // from the first cycle; it is small enough that this costs little.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_wr) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // FIFO pointers, level and sticky overrun (set beats clear)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rx_overrun_o <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_stb && full && !do_rd) rx_overrun_o <= 1'b1;
      else if (ov_clr_i)            rx_overrun_o <= 1'b0;
    end
  end

  assign to_clr = do_rd || wr_stb || (state_q != IDLE) || empty;

  // Idle timeout: counts whole bit times with data waiting, saturating
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                             to_cnt <= '0;
    else if (to_clr)                          to_cnt <= '0;
    else if (tick_wrap && to_cnt < CW'(TO_BITS)) to_cnt <= to_cnt + 1'b1;
  end

  assign head           = mem[rd_ptr];
  assign rx_data_o      = empty ? 8'h00 : head.data;
  assign err_parity_o   = !empty && head.perr;
  assign err_frame_o    = !empty && head.ferr;
  assign err_break_o    = !empty && head.brk;
  assign rx_full_o      = full;
  assign rx_not_empty_o = !empty;
  assign rx_level_o     = count;
  assign rx_thr_o       = (rx_thr_i != '0) && (count >= rx_thr_i);
  assign rx_timeout_o   = (to_cnt >= CW'(TO_BITS));

endmodule

// File: tb/tb_uart_rx_multi.sv
// Self-checking bench for uart_rx_multi: directed scenarios plus a random
// batch, all compared against a frame-level reference model and queue.
module tb_uart_rx_multi;

  localparam int OSR      = 16;
  localparam int FIFO_AW  = 4;
  localparam int TO_BITS  = 40;
  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OSR * TICK_DIV;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             baud_tick_i = 1'b0;
  logic             rx_i;
  logic [1:0]       data_bits_i;
  logic             parity_en_i, even_parity_i, stop2_i;
  logic             rd_en_i, ov_clr_i;
  logic [FIFO_AW:0] rx_thr_i;
  logic [7:0]       rx_data_o;
  logic             err_parity_o, err_frame_o, err_break_o;
  logic             rx_overrun_o, rx_full_o, rx_not_empty_o;
  logic [FIFO_AW:0] rx_level_o;
  logic             rx_thr_o, rx_timeout_o;

  uart_rx_multi #(.OSR(OSR), .FIFO_AW(FIFO_AW), .TO_BITS(TO_BITS)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .baud_tick_i(baud_tick_i), .rx_i(rx_i),
    .data_bits_i(data_bits_i), .parity_en_i(parity_en_i),
    .even_parity_i(even_parity_i), .stop2_i(stop2_i), .rd_en_i(rd_en_i),
    .ov_clr_i(ov_clr_i), .rx_thr_i(rx_thr_i), .rx_data_o(rx_data_o),
    .err_parity_o(err_parity_o), .err_frame_o(err_frame_o),
    .err_break_o(err_break_o), .rx_overrun_o(rx_overrun_o),
    .rx_full_o(rx_full_o), .rx_not_empty_o(rx_not_empty_o),
    .rx_level_o(rx_level_o), .rx_thr_o(rx_thr_o), .rx_timeout_o(rx_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Oversample tick: one clock in TICK_DIV, changed on the falling edge
  int div_cnt = 0;
  always @(negedge clk_i) begin
    div_cnt     = (div_cnt + 1) % TICK_DIV;
    baud_tick_i = (div_cnt == 0);
  end

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t model_q[$];
  bit   exp_ov;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected FIFO entry for one frame, from the line-level rules
  function automatic exp_t model_frame(input logic [7:0] d, input int nb,
                                       input bit pen, input bit even,
                                       input bit pbit, input bit s1,
                                       input bit s2, input bit st2);
    exp_t       e;
    logic [7:0] m;
    int         ones;
    m    = d & 8'((1 << nb) - 1);
    ones = $countones(m) + int'(pen && pbit);
    if (m == 8'h00 && !(pen && pbit) && !s1 && !(st2 && s2)) begin
      e.data = 8'h00; e.perr = 1'b0; e.ferr = 1'b1; e.brk = 1'b1;
    end else begin
      e.data = m;
      e.perr = pen && ((ones % 2) != (even ? 0 : 1));
      e.ferr = !s1 || (st2 && !s2);
      e.brk  = 1'b0;
    end
    return e;
  endfunction

  function automatic void push_model(input exp_t e);
    if (model_q.size() < DEPTH) model_q.push_back(e);
    else                        exp_ov = 1'b1;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic idle_bits(input int n);
    rx_i = 1'b1;
    wait_clks(n * BIT_CLKS);
  endtask

  // One bit time; optionally a one-tick inverted glitch in the middle
  task automatic drive_bit(input bit v, input bit glitch);
    rx_i = v;
    if (glitch) begin
      wait_clks(BIT_CLKS / 2);
      rx_i = ~v;
      wait_clks(TICK_DIV);
      rx_i = v;
      wait_clks(BIT_CLKS / 2 - TICK_DIV);
    end else begin
      wait_clks(BIT_CLKS);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen,
                            input bit even, input bit flip, input bit s1,
                            input bit s2, input bit st2, input int gbit);
    bit pc, pbit;
    data_bits_i   = 2'(nb - 5);
    parity_en_i   = pen;
    even_parity_i = even;
    stop2_i       = st2;
    pc   = ^(d & 8'((1 << nb) - 1));
    pbit = (even ? pc : ~pc) ^ flip;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i], gbit == i);
    if (pen) drive_bit(pbit, 1'b0);
    drive_bit(s1, 1'b0);
    if (st2) drive_bit(s2, 1'b0);
    push_model(model_frame(d, nb, pen, even, pbit, s1, s2, st2));
  endtask

  // Compare the head against the model, then pop it
  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_ne"}, 32'(rx_not_empty_o), 32'd1);
    if (model_q.size() != 0) begin
      e = model_q.pop_front();
      check({tag, "_data"}, 32'(rx_data_o), 32'(e.data));
      check({tag, "_flags"}, {29'd0, err_parity_o, err_frame_o, err_break_o},
            {29'd0, e.perr, e.ferr, e.brk});
    end
    rd_en_i = 1'b1;
    @(negedge clk_i);
    rd_en_i = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {8'd0, rx_data_o, err_parity_o, err_frame_o, err_break_o,
            rx_overrun_o, rx_full_o, rx_not_empty_o, rx_level_o,
            rx_thr_o, rx_timeout_o};
  endfunction

  // Watchdog: the sequence below is bounded, this only guards a hang
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    logic [7:0]  d;
    int          nb;
    bit          pen, even, st2, flip, s1, s2, last_stop;
    exp_t        dummy;

    rst_n_i = 1'b0; rx_i = 1'b1; rd_en_i = 1'b0; ov_clr_i = 1'b0;
    data_bits_i = 2'b11; parity_en_i = 1'b0; even_parity_i = 1'b0;
    stop2_i = 1'b0; rx_thr_i = '0; exp_ov = 1'b0;
    #1;
    check("reset_outs", all_outs(), 32'd0);
    wait_clks(4);
    rst_n_i = 1'b1;
    idle_bits(2);
    check("idle_outs", all_outs(), 32'd0);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 0, 0, 0, 1, 1, 0, -1);
    check("8n1_level", 32'(rx_level_o), 32'd1);
    check("8n1_lit", 32'(rx_data_o), 32'hA5);
    pop_check("8n1");
    check("8n1_empty", 32'(rx_not_empty_o), 32'd0);

    // 7E2, wrong parity bit, then a bad second stop bit
    send_frame(8'h35, 7, 1, 1, 1, 1, 1, 1, -1);
    check("7e2_perr_lit", 32'(err_parity_o), 32'd1);
    pop_check("7e2_par");
    send_frame(8'h4C, 7, 1, 1, 0, 1, 0, 1, -1);
    idle_bits(1);
    check("7e2_ferr_lit", 32'(err_frame_o), 32'd1);
    pop_check("7e2_stop");

    // False start, then a mid-bit glitch masked by the vote
    data_bits_i = 2'b11; parity_en_i = 1'b0; stop2_i = 1'b0;
    rx_i = 1'b0;
    wait_clks(4 * TICK_DIV);
    idle_bits(2);
    check("false_start_level", 32'(rx_level_o), 32'd0);
    send_frame(8'h3C, 8, 0, 0, 0, 1, 1, 0, 2);
    check("glitch_level", 32'(rx_level_o), 32'd1);
    pop_check("glitch");

    // Break: line low for two frame times, one entry only
    rx_i = 1'b0;
    wait_clks(20 * BIT_CLKS);
    push_model(model_frame(8'h00, 8, 0, 0, 0, 0, 0, 0));
    check("brk_level", 32'(rx_level_o), 32'd1);
    wait_clks(5 * BIT_CLKS);
    check("brk_hold_level", 32'(rx_level_o), 32'd1);
    idle_bits(2);
    check("brk_after_level", 32'(rx_level_o), 32'd1);
    check("brk_flag_lit", 32'(err_break_o), 32'd1);
    pop_check("brk");

    // Random frames with random format, errors and gaps
    for (int k = 0; k < 10; k++) begin
      d    = 8'($urandom);
      nb   = 5 + int'($urandom_range(0, 3));
      pen  = 1'($urandom); even = 1'($urandom); st2 = 1'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      s1   = ($urandom_range(0, 4) != 0);
      s2   = ($urandom_range(0, 4) != 0);
      send_frame(d, nb, pen, even, flip, s1, s2, st2, -1);
      last_stop = st2 ? s2 : s1;
      if (!last_stop || $urandom_range(0, 1) == 1) idle_bits(1);
    end
    check("rand_level", 32'(rx_level_o), 32'(model_q.size()));
    while (model_q.size() != 0) pop_check("rand");
    check("rand_empty", 32'(rx_not_empty_o), 32'd0);

    // Overrun: 17 back-to-back characters into a 16-deep FIFO
    for (int k = 0; k < DEPTH + 1; k++)
      send_frame(8'($urandom), 8, 0, 0, 0, 1, 1, 0, -1);
    check("ovr_full", 32'(rx_full_o), 32'd1);
    check("ovr_flag", 32'(rx_overrun_o), 32'(exp_ov));
    check("ovr_level", 32'(rx_level_o), 32'(DEPTH));
    ov_clr_i = 1'b1; exp_ov = 1'b0;
    @(negedge clk_i);
    ov_clr_i = 1'b0;
    check("ovr_clr", 32'(rx_overrun_o), 32'd0);
    check("rw_head", 32'(rx_data_o), 32'(model_q[0].data));
    seen = 1'b0;
    fork
      send_frame(8'h96, 8, 0, 0, 0, 1, 1, 0, -1);
      begin
        for (int i = 0; i < 20 * BIT_CLKS; i++) begin
          @(negedge clk_i);
          if (dut.wr_stb === 1'b1) begin
            rd_en_i = 1'b1;
            dummy   = model_q.pop_front();
            @(negedge clk_i);
            rd_en_i = 1'b0;
            seen    = 1'b1;
            break;
          end
        end
      end
    join
    check("rw_seen", 32'(seen), 32'd1);
    check("rw_level", 32'(rx_level_o), 32'(DEPTH));
    check("rw_ovr", 32'(rx_overrun_o), 32'(exp_ov));
    for (int k = 0; k < DEPTH; k++) pop_check("ovr_drain");
    check("ovr_empty", 32'(rx_level_o), 32'd0);

    // Threshold and idle timeout
    rx_thr_i = 5'd3;
    for (int k = 0; k < 3; k++) begin
      send_frame(8'($urandom), 8, 0, 0, 0, 1, 1, 0, -1);
      check("thr", 32'(rx_thr_o), 32'(model_q.size() >= 3));
    end
    idle_bits(TO_BITS - 2);
    check("to_early", 32'(rx_timeout_o), 32'd0);
    idle_bits(4);
    check("to_set", 32'(rx_timeout_o), 32'd1);
    pop_check("to_pop");
    check("to_clr", 32'(rx_timeout_o), 32'd0);
    check("thr_clr", 32'(rx_thr_o), 32'd0);

    // Reset in the middle of a frame
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    rx_thr_i = 5'd1;
    check("pre_rst_level", 32'(rx_level_o), 32'(model_q.size()));
    rst_n_i = 1'b0;
    #1;
    check("midrst_outs", all_outs(), 32'd0);
    model_q.delete();
    wait_clks(3);
    rx_i = 1'b1;
    rst_n_i = 1'b1;
    idle_bits(1);
    check("post_rst_outs", all_outs(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
